wb_la_master: RTL and testbench



---
 rtl/wb_la_pkg.sv | 11 +
 rtl/wb_la_timeout.sv | 28 ++
 rtl/wb_la_master.sv | 108 ++++++++++
 tb/tb_wb_la_master.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/wb_la_pkg.sv
// Shared types and constants for the logic-analyzer driven Wishbone initiator.
package wb_la_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_la_state_t;

  localparam logic [31:0] WB_LA_TIMEOUT_DATA   = 32'hFFFF_FFFF;
  localparam logic [31:0] WB_LA_WRITE_RSP_DATA = 32'h0;
endpackage

// File: rtl/wb_la_timeout.sv
// Saturating wait counter: o_hit flags the cycle whose increment would reach
// TIMEOUT_CYCLES, so stb spans exactly TIMEOUT_CYCLES cycles.
module wb_la_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_hit = i_en && (r_cnt == LAST);
endmodule

// File: rtl/wb_la_master.sv
// Single-transfer Wishbone classic initiator: one command in, one bus cycle,
// one response out, with a bounded wait that aborts on a silent slave.
module wb_la_master
  import wb_la_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);
  wb_la_state_t r_state, w_state_nxt;

  logic        r_cyc, r_we, r_rsp_err;
  logic [31:0] r_adr, r_dat, r_rsp_dat;
  logic [3:0]  r_sel;
  logic        w_accept, w_ack, w_hit, w_cnt_en;

  assign w_accept = (r_state == IDLE) && cmd_valid_i;
  assign w_ack    = (r_state == BUS) && wbm_ack_i;
  assign w_cnt_en = (r_state == BUS) && !wbm_ack_i;

  wb_la_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_accept),
    .i_en  (w_cnt_en),
    .o_hit (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i) w_state_nxt = BUS;
      BUS:     if (wbm_ack_i || w_hit) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cyc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= (w_state_nxt == BUS);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
    end else if (w_accept) begin
      r_we  <= cmd_we_i;
      r_adr <= cmd_adr_i;
      r_dat <= cmd_dat_i;
      r_sel <= cmd_sel_i;
    end
  end

  // Ack is checked first so a late ack on the timeout edge still returns data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_ack) begin
      r_rsp_dat <= r_we ? WB_LA_WRITE_RSP_DATA : wbm_dat_i;
      r_rsp_err <= 1'b0;
    end else if (w_hit) begin
      r_rsp_dat <= WB_LA_TIMEOUT_DATA;
      r_rsp_err <= 1'b1;
    end
  end

  assign cmd_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign busy_o      = (r_state != IDLE);
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;
endmodule

// File: tb/tb_wb_la_master.sv
// Directed and randomized bench for wb_la_master with an in-bench slave and
// a transaction-level model of the expected response.
module tb_wb_la_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_la_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: stb lasts until the ack cycle, capped at the timeout length.
  function automatic int exp_stb(input int ack_after);
    return (ack_after < 0 || ack_after >= TO) ? TO : ack_after + 1;
  endfunction

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_after, input logic [31:0] sdat,
                         input int hold, input logic stray, input logic pend);
    int nstb, guard;
    logic bad, e_err;
    logic [31:0] e_dat;
    e_err = (ack_after < 0 || ack_after >= TO);
    e_dat = e_err ? 32'hFFFF_FFFF : (we ? 32'h0 : sdat);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(posedge clk); @(negedge clk);
    cmd_valid_i = 1'b0; cmd_we_i = 1'($urandom); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);
    chk("rsp_valid_early", 32'(rsp_valid_o), 32'd0);
    nstb = 0; guard = 0; bad = 1'b0;
    while (wbm_stb_o && guard < 200) begin
      nstb++; guard++;
      if (wbm_cyc_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== adr || wbm_dat_o !== dat ||
          wbm_sel_o !== sel || rsp_valid_o !== 1'b0) bad = 1'b1;
      wbm_ack_i = (ack_after >= 0 && nstb == ack_after + 1);
      wbm_dat_i = wbm_ack_i ? sdat : $urandom;
      @(posedge clk); @(negedge clk);
      wbm_ack_i = 1'b0;
    end
    chk("bus_fields", 32'(bad), 32'd0);
    chk("stb_cycles", 32'(nstb), 32'(exp_stb(ack_after)));
    chk("cyc_drop", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_dat", rsp_dat_o, e_dat);
    chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
    chk("resp_ctrl", 32'({cmd_ready_o, busy_o}), 32'b01);
    if (pend) begin
      cmd_valid_i = 1'b1; cmd_we_i = 1'($urandom); cmd_adr_i = $urandom;
    end
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 0) begin wbm_ack_i = 1'b1; wbm_dat_i = $urandom; end
      @(posedge clk); @(negedge clk);
      wbm_ack_i = 1'b0;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== e_dat || rsp_err_o !== e_err ||
          cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) chk("rsp_hold", 32'(bad), 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_release", 32'({rsp_valid_o, cmd_ready_o, wbm_cyc_o, busy_o}), 32'b0100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
    cmd_sel_i = '0; rsp_ready_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, wbm_cyc_o, wbm_stb_o,
                           wbm_we_o}), 32'b1000000);
    chk("reset_data", rsp_dat_o | wbm_adr_o | wbm_dat_o | 32'(wbm_sel_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 3, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3, -1, 32'h0, 2, 1'b1, 1'b0);
    run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, TO - 1, 32'h1234_5678, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'hC, 1, 32'h0, 5, 1'b0, 1'b1);
    run_cmd(1'b0, 32'h3000_0034, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 0, 1'b0, 1'b0);

    // Abort a bus cycle with reset on its second wait cycle.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0040; cmd_sel_i = 4'hF;
    @(posedge clk); @(negedge clk);
    cmd_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_in_bus", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}), 32'b0001);
    run_cmd(1'b1, 32'h3000_0044, 32'h0F0F_F0F0, 4'h1, 2, 32'h0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int r;
      r = int'($urandom_range(0, 10));
      run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), (r >= 9) ? -1 : r, $urandom,
              int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
